// File: rtl/fpmul_stage2_iter.sv
// FP multiplier stage 2: iterative shift-add 24x24 significand product and rebiased exponent sum.
// Optional FPMUL_STAGE2_FASTPATH_EN: exception pairs bypass MUL and go straight to DONE.
module fpmul_stage2_iter #(
    parameter int BITS_PER_CYCLE = 4,
    parameter int EXP_BIAS       = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  A_EXP,
    input  logic [31:0] A_SIG,
    input  logic [7:0]  B_EXP,
    input  logic [31:0] B_SIG,
    input  logic        SIGN_out_stage1,
    input  logic        isINF_stage1,
    input  logic        isNaN_stage1,
    input  logic        isZ_tab_stage1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] SIG_out_stage2,
    output logic [9:0]  EXP_out_stage2,
    output logic        SIGN_out_stage2,
    output logic        isINF_stage2,
    output logic        isNaN_stage2,
    output logic        isZ_tab_stage2
);
    localparam int         ITER     = 24 / BITS_PER_CYCLE;
    localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t        state_q, state_d;
    logic [47:0]   mcand_q;
    logic [23:0]   mplier_q;
    logic [47:0]   acc_q;
    logic [4:0]    cnt_q;
    logic [9:0]    exp_q;
    logic          sign_q, inf_q, nan_q, z_q;
    logic          out_valid_q;
    logic          exc_in, exc_q;
    logic [47:0]   pp;

    assign exc_in = isINF_stage1 | isNaN_stage1 | isZ_tab_stage1;
    assign exc_q  = inf_q | nan_q | z_q;

    // Multiplicand is pre-shifted each step, so the partial product lands at its final weight.
    assign pp = mcand_q * {{(48-BITS_PER_CYCLE){1'b0}}, mplier_q[BITS_PER_CYCLE-1:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef FPMUL_STAGE2_FASTPATH_EN
                    state_d = exc_in ? DONE : MUL;
`else
                    state_d = MUL;
`endif
                end
            end
            MUL:     if (cnt_q == 5'd0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            z_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mcand_q  <= {24'b0, A_SIG[23:0]};
                        mplier_q <= B_SIG[23:0];
                        acc_q    <= '0;
                        cnt_q    <= CNT_LAST;
                        exp_q    <= {2'b0, A_EXP} + {2'b0, B_EXP} - 10'(EXP_BIAS);
                        sign_q   <= SIGN_out_stage1;
                        inf_q    <= isINF_stage1;
                        nan_q    <= isNaN_stage1;
                        z_q      <= isZ_tab_stage1;
                    end
                end
                MUL: begin
                    // Exception pairs keep the accumulator at zero so the forced result falls out naturally.
                    if (!exc_q) acc_q <= acc_q + pp;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready        = (state_q == IDLE);
    assign out_valid       = out_valid_q;
    assign SIG_out_stage2  = {16'b0, acc_q};
    assign EXP_out_stage2  = exp_q;
    assign SIGN_out_stage2 = sign_q;
    assign isINF_stage2    = inf_q;
    assign isNaN_stage2    = nan_q;
    assign isZ_tab_stage2  = z_q;
endmodule

// File: tb/tb_fpmul_stage2_iter.sv
// Directed self-checking bench for fpmul_stage2_iter (default BITS_PER_CYCLE plus 1/2/8 variants).
module tb_fpmul_stage2_iter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  A_EXP = '0, B_EXP = '0;
    logic [31:0] A_SIG = '0, B_SIG = '0;
    logic        sgn_i = 1'b0, inf_i = 1'b0, nan_i = 1'b0, z_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] SIG_o;
    logic [9:0]  EXP_o;
    logic        sgn_o, inf_o, nan_o, z_o;

    logic [2:0]  x_ir, x_ov, x_sgn, x_inf, x_nan, x_z;
    logic [63:0] x_sig [3];
    logic [9:0]  x_exp [3];

    int total = 0;
    int bad   = 0;

`ifdef FPMUL_STAGE2_FASTPATH_EN
    localparam int EXC_LAT = 1;
`else
    localparam int EXC_LAT = 7;
`endif

    always #5 clk = ~clk;

    fpmul_stage2_iter #(.BITS_PER_CYCLE(4), .EXP_BIAS(127)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A_EXP(A_EXP), .A_SIG(A_SIG), .B_EXP(B_EXP), .B_SIG(B_SIG),
        .SIGN_out_stage1(sgn_i), .isINF_stage1(inf_i), .isNaN_stage1(nan_i), .isZ_tab_stage1(z_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .SIG_out_stage2(SIG_o), .EXP_out_stage2(EXP_o), .SIGN_out_stage2(sgn_o),
        .isINF_stage2(inf_o), .isNaN_stage2(nan_o), .isZ_tab_stage2(z_o)
    );

    for (genvar g = 0; g < 3; g++) begin : g_var
        localparam int BP = (g == 0) ? 1 : (g == 1) ? 2 : 8;
        fpmul_stage2_iter #(.BITS_PER_CYCLE(BP), .EXP_BIAS(127)) u_var (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x_ir[g]),
            .A_EXP(A_EXP), .A_SIG(A_SIG), .B_EXP(B_EXP), .B_SIG(B_SIG),
            .SIGN_out_stage1(sgn_i), .isINF_stage1(inf_i), .isNaN_stage1(nan_i), .isZ_tab_stage1(z_i),
            .out_valid(x_ov[g]), .out_ready(out_ready),
            .SIG_out_stage2(x_sig[g]), .EXP_out_stage2(x_exp[g]), .SIGN_out_stage2(x_sgn[g]),
            .isINF_stage2(x_inf[g]), .isNaN_stage2(x_nan[g]), .isZ_tab_stage2(x_z[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] ae, input logic [31:0] as, input logic [7:0] be,
                         input logic [31:0] bs, input logic s, input logic inf, input logic nan,
                         input logic z);
        A_EXP = ae; A_SIG = as; B_EXP = be; B_SIG = bs;
        sgn_i = s; inf_i = inf; nan_i = nan; z_i = z;
    endtask

    // Accept edge counts as latency 1; returns once out_valid is seen (or the bound expires).
    task automatic run_op(input logic [7:0] ae, input logic [31:0] as, input logic [7:0] be,
                          input logic [31:0] bs, input logic s, input logic inf, input logic nan,
                          input logic z, output int lat);
        @(negedge clk);
        drive(ae, as, be, bs, s, inf, nan, z);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) chk("timeout", 64'(lat), 64'd0);
    endtask

    task automatic finish_op();
        @(posedge clk);
        #1 chk("drop_valid", 64'(out_valid), 64'd0);
    endtask

    int lat;
    int lat_m;
    int lat_x [3];
    logic [63:0] sig_x [3];
    logic [9:0]  exp_x [3];
    logic [2:0]  sgn_x;
    logic [63:0] sig_m;
    logic [9:0]  exp_m;
    logic        sgn_m;

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sig", SIG_o, 64'd0);
        chk("rst_exp", 64'(EXP_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1.5 x 2.0
        run_op(8'h7F, 32'h00C00000, 8'h80, 32'h00800000, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        chk("t1_lat", 64'(lat), 64'd7);
        chk("t1_sig", SIG_o, 64'h0000_6000_0000_0000);
        chk("t1_exp", 64'(EXP_o), 64'h080);
        chk("t1_sign", 64'(sgn_o), 64'd0);
        chk("t1_flags", 64'({inf_o, nan_o, z_o}), 64'd0);
        chk("t1_in_ready", 64'(in_ready), 64'd0);
        finish_op();
        repeat (30) @(posedge clk);

        // Max significands/exponents on all four datapath widths at once
        @(negedge clk);
        drive(8'hFE, 32'h00FFFFFF, 8'hFE, 32'h00FFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat_m = 0;
        for (int k = 0; k < 3; k++) lat_x[k] = 0;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid && lat_m == 0) begin
                lat_m = c; sig_m = SIG_o; exp_m = EXP_o; sgn_m = sgn_o;
            end
            for (int k = 0; k < 3; k++) begin
                if (x_ov[k] && lat_x[k] == 0) begin
                    lat_x[k] = c; sig_x[k] = x_sig[k]; exp_x[k] = x_exp[k]; sgn_x[k] = x_sgn[k];
                end
            end
            @(posedge clk);
            #1;
        end
        chk("t2_bpc4_lat", 64'(lat_m), 64'd7);
        chk("t2_bpc4_sig", sig_m, 64'h0000_FFFF_FE00_0001);
        chk("t2_bpc4_exp", 64'(exp_m), 64'h17D);
        chk("t2_bpc4_sign", 64'(sgn_m), 64'd1);
        chk("t2_bpc1_lat", 64'(lat_x[0]), 64'd25);
        chk("t2_bpc2_lat", 64'(lat_x[1]), 64'd13);
        chk("t2_bpc8_lat", 64'(lat_x[2]), 64'd4);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t2_var%0d_sig", k), sig_x[k], 64'h0000_FFFF_FE00_0001);
            chk($sformatf("t2_var%0d_exp", k), 64'(exp_x[k]), 64'h17D);
            chk($sformatf("t2_var%0d_sign", k), 64'(sgn_x[k]), 64'd1);
        end

        // Exponent underflow range
        run_op(8'h01, 32'h00800000, 8'h01, 32'h00800000, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        chk("t3_exp", 64'(EXP_o), 64'h383);
        chk("t3_sig", SIG_o, 64'h0000_4000_0000_0000);
        finish_op();

        // Backpressure with a competing pair held on the input
        out_ready = 1'b0;
        run_op(8'h7F, 32'h00FFFFFF, 8'h7F, 32'h00800001, 1'b1, 1'b0, 1'b0, 1'b0, lat);
        chk("t4_lat", 64'(lat), 64'd7);
        chk("t4_sig", SIG_o, 64'h0000_8000_007F_FFFF);
        chk("t4_exp", 64'(EXP_o), 64'h07F);
        @(negedge clk);
        drive(8'h81, 32'h00A00000, 8'h7E, 32'h00C00000, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_hold_ready", 64'(in_ready), 64'd0);
            chk("t4_hold_sig", SIG_o, 64'h0000_8000_007F_FFFF);
            chk("t4_hold_exp_sign", 64'({EXP_o, sgn_o}), 64'({10'h07F, 1'b1}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_hs_valid", 64'(out_valid), 64'd0);
        chk("t4_hs_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("t4_acc2_ready", 64'(in_ready), 64'd0);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1 lat++;
        end
        chk("t4_pair2_lat", 64'(lat), 64'd7);
        chk("t4_pair2_sig", SIG_o, 64'h0000_7800_0000_0000);
        chk("t4_pair2_exp", 64'(EXP_o), 64'h080);
        finish_op();
        repeat (30) @(posedge clk);

        // Exception pairs: product forced to zero, flags and exponent still reported
        run_op(8'h7F, 32'h00C00000, 8'h80, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, lat);
        chk("t5_nan_lat", 64'(lat), 64'(EXC_LAT));
        chk("t5_nan_sig", SIG_o, 64'd0);
        chk("t5_nan_flags", 64'({inf_o, nan_o, z_o}), 64'b010);
        finish_op();
        run_op(8'h7F, 32'h00C00000, 8'h80, 32'h00800000, 1'b1, 1'b1, 1'b0, 1'b0, lat);
        chk("t5_inf_lat", 64'(lat), 64'(EXC_LAT));
        chk("t5_inf_sig", SIG_o, 64'd0);
        chk("t5_inf_exp", 64'(EXP_o), 64'h080);
        chk("t5_inf_sign_flags", 64'({sgn_o, inf_o, nan_o, z_o}), 64'b1100);
        finish_op();
        repeat (30) @(posedge clk);

        // Reset during MUL
        @(negedge clk);
        drive(8'h80, 32'h00FFFFFF, 8'h80, 32'h00FFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_ready", 64'(in_ready), 64'd1);
        chk("t6_rst_sig", SIG_o, 64'd0);
        chk("t6_rst_exp_sign", 64'({EXP_o, sgn_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h7F, 32'h00C00000, 8'h80, 32'h00800000, 1'b0, 1'b0, 1'b0, 1'b0, lat);
        chk("t6_lat", 64'(lat), 64'd7);
        chk("t6_sig", SIG_o, 64'h0000_6000_0000_0000);
        chk("t6_exp", 64'(EXP_o), 64'h080);
        finish_op();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpmul_stage2_iter.md
Name: fpmul_stage2_iter

Overview:
Second stage of the FP multiplier pipeline. It consumes the registered unpacked operands and exception flags produced by stage 1, and computes the 48-bit significand product with an iterative shift-add datapath. It also produces the rebiased exponent sum. It replaces a single-cycle 24x24 array with a multi-cycle FSM behind a valid/ready handshake, so stage 3 (normalise/round/pack) can apply backpressure.

Parameters:
BITS_PER_CYCLE, 4, number of multiplier bits retired per iteration. Legal values are 1, 2, 3, 4, 6 and 8. ITER = 24/BITS_PER_CYCLE.
EXP_BIAS, 127, bias subtracted from the exponent sum.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  stage-1 outputs are valid
in_ready  out  1  block accepts an operand pair
A_EXP  in  8  biased exponent of A
A_SIG  in  32  unpacked significand of A; hidden bit at [23], bits [31:24] are zero
B_EXP  in  8  biased exponent of B
B_SIG  in  32  unpacked significand of B; same layout as A_SIG
SIGN_out_stage1  in  1  result sign
isINF_stage1  in  1  result is infinity
isNaN_stage1  in  1  result is NaN
isZ_tab_stage1  in  1  result is zero
out_valid  out  1  stage-2 result valid
out_ready  in  1  stage 3 accepts the result
SIG_out_stage2  out  64  product; [47:0] = A_SIG[23:0]*B_SIG[23:0], [63:48] = 0
EXP_out_stage2  out  10  two's-complement A_EXP + B_EXP - EXP_BIAS
SIGN_out_stage2  out  1  registered copy of the sign
isINF_stage2  out  1  registered copy of isINF
isNaN_stage2  out  1  registered copy of isNaN
isZ_tab_stage2  out  1  registered copy of isZ_tab

Behaviour:
- Reset (async assert, sync deassert by design):
  - state = IDLE; in_ready = 1; out_valid = 0.
  - All data outputs and flags = 0; internal accumulator and counter = 0.
- Reset mid-operation aborts the operation with no output. The first acceptance after reset starts a clean operation.
- FSM has three states: IDLE, MUL, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture A_SIG[23:0] and B_SIG[23:0]; clear the accumulator; set counter = ITER-1.
  - Register EXP = {2'b0,A_EXP} + {2'b0,B_EXP} - EXP_BIAS, computed in 10 bits with wraparound. This is exact for the range -127..383; no saturation.
  - Register the sign and the three flags; go to MUL.
  - Inputs are ignored when in_valid = 0.
- MUL:
  - in_ready = 0.
  - Each cycle: acc += (multiplicand * multiplier[BITS_PER_CYCLE-1:0]) << (BITS_PER_CYCLE * step); the multiplier shifts right by BITS_PER_CYCLE; the counter decrements.
  - When the counter is 0, the final partial product is added and the state goes to DONE.
  - Exactly ITER cycles are spent in MUL.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - All outputs stay stable until out_ready = 1. On that handshake edge the state goes to IDLE and out_valid drops.
  - out_valid is registered and never depends combinationally on out_ready.
- Latency: out_valid is high ITER+1 cycles after the accept edge (7 at the default BITS_PER_CYCLE = 4).
- Throughput: at most one result per ITER+2 cycles. There is no overlap of accept and deliver.
- Exception forcing: if any of isINF/isNaN/isZ_tab is set for the operand pair, SIG_out_stage2 = 0 in DONE. The exponent and sign are still reported.
- Flags pass through unmodified. Stage 2 never creates new exception conditions.

Optional Feature:
FPMUL_STAGE2_FASTPATH_EN
- Defined: in IDLE, an accepted pair with any exception flag set goes directly to DONE with SIG_out_stage2 = 0. out_valid is high 1 cycle after the accept edge.
- Undefined: every pair takes the full ITER MUL cycles. Outputs are identical in both builds; only latency differs.

Test Plan:
1. Multiply 1.5 by 2.0. Stimulus: A_SIG = 0x00C00000, A_EXP = 0x7F, B_SIG = 0x00800000, B_EXP = 0x80, sign 0, no flags, out_ready = 1. Required: SIG_out_stage2 = 0x0000_6000_0000_0000 and EXP_out_stage2 = 0x080, with out_valid high exactly 7 cycles after accept.
2. Maximum significands and exponents. Stimulus: A_SIG = B_SIG = 0x00FFFFFF, A_EXP = B_EXP = 0xFE, sign in = 1, at each BITS_PER_CYCLE in {1,2,4,8}. Required: SIG_out_stage2 = 0xFFFF_FE00_0001, EXP_out_stage2 = 0x17D, SIGN_out_stage2 = 1, with latency 25, 13, 7 and 4 cycles respectively.
3. Exponent underflow range. Stimulus: A_EXP = B_EXP = 0x01. Required: EXP_out_stage2 = 0x383 (-125).
4. Backpressure and input blocking. Stimulus: hold out_ready = 0 for 10 cycles in DONE while driving new in_valid with different data. Required: outputs and out_valid stay stable, in_ready stays 0, and the second pair is accepted only after the out handshake and IDLE.
5. Exception pair. Stimulus: isNaN_stage1 = 1 with A_SIG = 0x00C00000, B_SIG = 0. Required: SIG_out_stage2 = 0 and isNaN_stage2 = 1; latency is 1 cycle with FPMUL_STAGE2_FASTPATH_EN defined and 7 cycles without.
6. Reset mid-operation. Stimulus: assert rst_n = 0 during MUL cycle 3. Required: out_valid = 0, in_ready = 1 and outputs = 0 immediately (asynchronously); after release, a new 1.5 x 2.0 pair returns the correct result with no stale data.
